// File: rtl/qr_pkg.sv
// ============================================================================
//  Package    : qr_pkg
//  Description: Shared types, widths and element helpers for qr_row_collector.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package qr_pkg;

  localparam int LENGTH = 13;
  localparam int BUS    = 4;
  localparam int N_ROW  = 8;
  localparam int CNT_W  = 9;
  localparam int ROW_W  = BUS * LENGTH;

  typedef logic [LENGTH-1:0] elem_t;
  typedef logic [ROW_W-1:0]  row_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_t;

  function automatic elem_t get_elem(row_t row, logic [1:0] k);
    return row[int'(k)*LENGTH +: LENGTH];
  endfunction

  // Clipped CORDIC results sit at the two's-complement extremes.
  function automatic logic is_sat(elem_t e);
    return (e == elem_t'(13'h0FFF)) || (e == elem_t'(13'h1000));
  endfunction

  function automatic logic row_has_sat(row_t row);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < BUS; k++) begin
      hit = hit | is_sat(row[k*LENGTH +: LENGTH]);
    end
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qr_latency_counter.sv
// ============================================================================
//  Module     : qr_latency_counter
//  Description: Start/stop saturating cycle counter; the stop edge still counts.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module qr_latency_counter
  import qr_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [WIDTH-1:0] count_o
);

  logic             running_q;
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      running_q <= 1'b0;
      count_q   <= '0;
    end else if (start_i) begin
      count_q   <= '0;
      running_q <= !stop_i;
    end else if (running_q) begin
      if (count_q != '1) begin
        count_q <= count_q + WIDTH'(1);
      end
      if (stop_i) begin
        running_q <= 1'b0;
      end
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/qr_row_collector.sv
// ============================================================================
//  Module     : qr_row_collector
//  Description: Captures the 8-row QR_CORDIC result burst and serves element
//               reads; measures start-to-result latency.
//               Optional build macro QR_COLLECT_SAT_FLAG_EN adds sat_flag/sat_any.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module qr_row_collector
  import qr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             out_vallid,
  input  logic [ROW_W-1:0] out,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [2:0]       rd_row,
  input  logic [1:0]       rd_col,
  output logic             rd_ack,
  output logic [LENGTH-1:0] rd_data,
  output logic             rd_err,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] calc_cycles
`ifdef QR_COLLECT_SAT_FLAG_EN
  ,
  output logic             sat_flag,
  output logic             sat_any
`endif
);

  state_t     state_q;
  logic [2:0] beat_q;
  logic       ov_prev_q;
  logic       done_q;
  logic       overrun_q;
  logic       rd_ack_q;
  logic       rd_err_q;
  elem_t      rd_data_q;
  row_t       row_buf_q [N_ROW];

  logic       w_burst_start;
  logic       w_wr_en;
  logic [2:0] w_wr_idx;
  elem_t      w_rd_elem;

  // A burst is announced by the rising edge of out_vallid, so a held level
  // after capture does not retrigger.
  assign w_burst_start = out_vallid & ~ov_prev_q;
  assign w_rd_elem     = get_elem(row_buf_q[rd_row], rd_col);

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = 3'(N_ROW-1);
    if (!clr) begin
      if (state_q == CAPTURE) begin
        w_wr_en  = 1'b1;
        w_wr_idx = 3'(N_ROW-1) - beat_q;
      end else if (w_burst_start) begin
        w_wr_en  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && w_wr_en) begin
      row_buf_q[w_wr_idx] <= out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      beat_q    <= 3'd0;
      ov_prev_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ov_prev_q <= out_vallid;
      if (clr) begin
        state_q <= IDLE;
        beat_q  <= 3'd0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (w_burst_start) begin
              state_q <= CAPTURE;
              beat_q  <= 3'd1;
            end
          end
          CAPTURE: begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'(N_ROW-1)) begin
              state_q <= READY;
              beat_q  <= 3'd0;
              done_q  <= 1'b1;
            end
          end
          READY: begin
            if (w_burst_start) begin
              state_q   <= CAPTURE;
              beat_q    <= 3'd1;
              done_q    <= 1'b0;
              overrun_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
          end
        endcase
      end

      // Reads see the buffer before this edge's write.
      rd_ack_q <= rd_req;
      if (rd_req && (state_q == READY)) begin
        rd_data_q <= w_rd_elem;
        rd_err_q  <= 1'b0;
      end else begin
        rd_data_q <= '0;
        rd_err_q  <= rd_req;
      end
    end
  end

  qr_latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .stop_i  (out_vallid),
    .count_o (calc_cycles)
  );

`ifdef QR_COLLECT_SAT_FLAG_EN
  logic sat_flag_q;
  logic sat_any_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sat_flag_q <= 1'b0;
      sat_any_q  <= 1'b0;
    end else begin
      sat_flag_q <= rd_req && (state_q == READY) && is_sat(w_rd_elem);
      if (clr) begin
        sat_any_q <= 1'b0;
      end else if (w_wr_en && row_has_sat(out)) begin
        sat_any_q <= 1'b1;
      end
    end
  end

  assign sat_flag = sat_flag_q;
  assign sat_any  = sat_any_q;
`endif

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign rd_err  = rd_err_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

`default_nettype wire
